// File: rtl/cv32e40x_pkg.sv
// Shared core types for the divider: opcode encoding, FSM states, divide-by-zero quotient.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/cv32e40x_div_serial.sv
// Serial radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional CV32E40X_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass iteration.
module cv32e40x_div_serial
  import cv32e40x_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  input  logic [1:0]       div_operator_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             div_valid_o,
  input  logic             div_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  div_opcode_e      op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;

  div_opcode_e      op_in;
  logic             signed_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;

  assign op_in     = div_opcode_e'(div_operator_i);
  assign signed_in = (op_in == DIV_DIV) || (op_in == DIV_REM);
  assign abs_a     = (signed_in && op_a_i[WIDTH-1]) ? (~op_a_i + WIDTH'(1)) : op_a_i;
  assign abs_b     = (signed_in && op_b_i[WIDTH-1]) ? (~op_b_i + WIDTH'(1)) : op_b_i;

  // Restoring step: rem can reach 2^WIDTH-2, so the shifted value needs one extra bit
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, divisor};
  assign rem_sub = rem_sh[WIDTH-1:0] - divisor;

`ifdef CV32E40X_DIV_FAST_SPECIAL_EN
  logic special_zero;
  logic special_ovf;
  assign special_zero = (op_b_i == '0);
  assign special_ovf  = signed_in && (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_i == '1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= DIV_DIVU;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
    end else if (kill_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid_i) begin
            op      <= op_in;
            sign_a  <= signed_in && op_a_i[WIDTH-1];
            sign_b  <= signed_in && op_b_i[WIDTH-1];
            divisor <= abs_b;
            quo     <= abs_a;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
            state   <= CALC;
`ifdef CV32E40X_DIV_FAST_SPECIAL_EN
            // Preload what the iteration would converge to; the fixup stage finishes the job
            if (special_zero) begin
              quo   <= DIV_ZERO_QUOT;
              rem   <= abs_a;
              state <= DONE;
            end else if (special_ovf) begin
              quo   <= {1'b1, {(WIDTH-1){1'b0}}};
              rem   <= '0;
              state <= DONE;
            end
`endif
          end
        end
        CALC: begin
          rem <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], rem_ge};
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          if (div_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic             out_rem;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Sign flags are only ever set for signed ops, so unsigned results pass through
  assign out_rem = (op == DIV_REM) || (op == DIV_REMU);
  assign neg_quo = (sign_a ^ sign_b) && (divisor != '0);
  assign neg_rem = sign_a;
  assign quo_fix = neg_quo ? (~quo + WIDTH'(1)) : quo;
  assign rem_fix = neg_rem ? (~rem + WIDTH'(1)) : rem;

  assign div_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign div_valid_o = (state == DONE) && !kill_i;
  assign result_o    = (state == DONE) ? (out_rem ? rem_fix : quo_fix) : '0;

  a_width_legal: assert property (@(posedge clk) WIDTH == 32);

endmodule

// File: tb/tb_cv32e40x_div_serial.sv
// Self-checking bench for cv32e40x_div_serial against an arithmetic reference model.
module tb_cv32e40x_div_serial;
  import cv32e40x_pkg::*;

  logic        clk;
  logic        rst;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [1:0]  div_operator_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        kill_i;
  logic        div_valid_o;
  logic        div_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int tests;
  int fails;

  cv32e40x_div_serial #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .div_valid_i   (div_valid_i),
    .div_ready_o   (div_ready_o),
    .div_operator_i(div_operator_i),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .kill_i        (kill_i),
    .div_valid_o   (div_valid_o),
    .div_ready_i   (div_ready_i),
    .result_o      (result_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int  sa;
    int  sb;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_REMU: return (b == 0) ? a : a % b;
      DIV_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      default:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef CV32E40X_DIV_FAST_SPECIAL_EN
    logic sgn;
    sgn = (op == DIV_DIV) || (op == DIV_REM);
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    if (op == 2'b00 && a == 0 && b == 0) return 33;
    return 33;
`endif
  endfunction

  // Present a request in IDLE and let the accepting edge pass; inputs then scrambled
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    tests++;
    if (div_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_accept: got %b want 1", div_ready_o);
    end
    div_valid_i    = 1'b1;
    div_operator_i = op;
    op_a_i         = a;
    op_b_i         = b;
    @(posedge clk);
    #1;
    div_valid_i    = 1'b0;
    div_operator_i = 2'($urandom);
    op_a_i         = $urandom;
    op_b_i         = $urandom;
  endtask

  // Wait (bounded) for div_valid_o; latency counts edges from the accept edge inclusive
  task automatic wait_result(output int lat, output logic [31:0] res, output bit ok);
    lat = 1;
    ok  = 1'b0;
    res = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_valid_o === 1'b1) begin
        ok  = 1'b1;
        res = result_o;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: no div_valid_o within 100 cycles");
    end
  endtask

  // Called at the negedge where div_valid_o is seen: consume and check return to IDLE
  task automatic finish_op();
    tests++;
    if (div_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL ready_in_done: got %b want 0", div_ready_o);
    end
    div_ready_i = 1'b1;
    @(posedge clk);
    #1;
    div_ready_i = 1'b0;
    @(negedge clk);
    tests++;
    if (div_ready_o !== 1'b1 || div_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_handshake: ready=%b valid=%b busy=%b want 1 0 0",
               div_ready_o, div_valid_o, busy_o);
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [31:0] res;
    bit          ok;
    start_op(op, a, b);
    wait_result(lat, res, ok);
    if (ok) begin
      tests++;
      if (res !== ref_div(op, a, b)) begin
        fails++;
        $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", name, op, a, b, res, ref_div(op, a, b));
      end
      tests++;
      if (lat != ref_lat(op, a, b)) begin
        fails++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, ref_lat(op, a, b));
      end
      finish_op();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (div_ready_o !== 1'b1 || div_valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b result=%h busy=%b want 1 0 0 0",
               div_ready_o, div_valid_o, result_o, busy_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    check_op("div_100_7",      DIV_DIV,  32'd100,        32'd7);
    check_op("rem_100_7",      DIV_REM,  32'd100,        32'd7);
    check_op("div_m100_7",     DIV_DIV,  32'hFFFF_FF9C,  32'd7);
    check_op("rem_m100_7",     DIV_REM,  32'hFFFF_FF9C,  32'd7);
    check_op("divu_max_2",     DIV_DIVU, 32'hFFFF_FFFF,  32'd2);
    check_op("remu_max_2",     DIV_REMU, 32'hFFFF_FFFF,  32'd2);
    check_op("div_5_0",        DIV_DIV,  32'd5,          32'd0);
    check_op("div_m5_0",       DIV_DIV,  32'hFFFF_FFFB,  32'd0);
    check_op("rem_m5_0",       DIV_REM,  32'hFFFF_FFFB,  32'd0);
    check_op("divu_x_0",       DIV_DIVU, 32'h1234_5678,  32'd0);
    check_op("remu_x_0",       DIV_REMU, 32'h1234_5678,  32'd0);
    check_op("div_ovf",        DIV_DIV,  32'h8000_0000,  32'hFFFF_FFFF);
    check_op("rem_ovf",        DIV_REM,  32'h8000_0000,  32'hFFFF_FFFF);
    check_op("divu_min_max",   DIV_DIVU, 32'h8000_0000,  32'hFFFF_FFFF);
    check_op("div_min_min",    DIV_DIV,  32'h8000_0000,  32'h8000_0000);
    check_op("rem_7_m3",       DIV_REM,  32'd7,          32'hFFFF_FFFD);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      check_op("random", op, a, b);
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] res;
    bit          ok;
    bit          stable;
    start_op(DIV_DIVU, 32'd1000, 32'd33);
    wait_result(lat, res, ok);
    if (ok) begin
      stable = 1'b1;
      repeat (10) begin
        @(posedge clk);
        @(negedge clk);
        if (div_valid_o !== 1'b1 || result_o !== 32'd30) stable = 1'b0;
      end
      tests++;
      if (!stable) begin
        fails++;
        $display("FAIL backpressure_hold: valid=%b result=%h want 1 0000001e", div_valid_o, result_o);
      end
      finish_op();
    end
  endtask

  task automatic test_kill_calc();
    bit seen;
    start_op(DIV_DIV, 32'd12345, 32'd17);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    #1;
    tests++;
    if (div_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL kill_calc_valid: got %b want 0", div_valid_o);
    end
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    @(negedge clk);
    tests++;
    if (busy_o !== 1'b0 || div_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL kill_calc_idle: busy=%b ready=%b want 0 1", busy_o, div_ready_o);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_valid_o !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL kill_calc_no_result: got valid=1 want 0");
    end
  endtask

  task automatic test_kill_idle();
    @(negedge clk);
    div_valid_i    = 1'b1;
    kill_i         = 1'b1;
    div_operator_i = DIV_DIVU;
    op_a_i         = 32'd9;
    op_b_i         = 32'd3;
    @(posedge clk);
    #1;
    div_valid_i = 1'b0;
    kill_i      = 1'b0;
    @(negedge clk);
    tests++;
    if (busy_o !== 1'b0 || div_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL kill_idle_no_accept: busy=%b ready=%b want 0 1", busy_o, div_ready_o);
    end
  endtask

  task automatic test_kill_done();
    int          lat;
    logic [31:0] res;
    bit          ok;
    start_op(DIV_REMU, 32'd50, 32'd7);
    wait_result(lat, res, ok);
    if (ok) begin
      kill_i = 1'b1;
      #1;
      tests++;
      if (div_valid_o !== 1'b0) begin
        fails++;
        $display("FAIL kill_done_valid: got %b want 0", div_valid_o);
      end
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      @(negedge clk);
      tests++;
      if (busy_o !== 1'b0 || div_valid_o !== 1'b0) begin
        fails++;
        $display("FAIL kill_done_idle: busy=%b valid=%b want 0 0", busy_o, div_valid_o);
      end
    end
  endtask

  task automatic test_rst_mid();
    start_op(DIV_DIV, 32'hDEAD_BEEF, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (div_ready_o !== 1'b1 || div_valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_calc: ready=%b valid=%b result=%h busy=%b want 1 0 0 0",
               div_ready_o, div_valid_o, result_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first",  DIV_DIVU, 32'd77,         32'd10);
    check_op("b2b_second", DIV_REM,  32'hFFFF_FFB3,  32'd10);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst            = 1'b1;
    div_valid_i    = 1'b0;
    div_operator_i = 2'b00;
    op_a_i         = '0;
    op_b_i         = '0;
    kill_i         = 1'b0;
    div_ready_i    = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_kill_calc();
    test_kill_idle();
    test_kill_done();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
